// File: rtl/bus_fabric_pkg.sv
// Shared types for the CPU bus fabric: FSM states, the open-bus default and
// the per-region attribute record used by the access sequencer.
package bus_fabric_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fab_state_t;

  localparam int              WAIT_W           = 4;
  localparam logic [7:0]      OPEN_BUS_DEFAULT = 8'hEA;

  typedef struct packed {
    logic [WAIT_W-1:0] wait_cyc;
    logic              ro;
  } region_attr_t;

endpackage

// File: rtl/bus_region_decoder.sv
// Combinational address decoder: one-hot region select, hit flag and the
// binary index of the winning region (lowest matching index wins).
module bus_region_decoder
  import bus_fabric_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 3,
  parameter int IDX_W       = 2,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = '{16'h0000, 16'h4000, 16'h8000},
  parameter logic [ADDR_W-1:0] REGION_MASK [NUM_REGIONS] = '{16'hC000, 16'hF000, 16'h8000}
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] sel,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx
);

  // Scan from the top down so the lowest matching region is the last writer.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if ((addr & REGION_MASK[r]) == REGION_BASE[r]) begin
        sel    = '0;
        sel[r] = 1'b1;
        hit    = 1'b1;
        idx    = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// CPU bus fabric: decodes the CPU address into register regions, inserts
// per-region wait states via RDY, and flags unmapped / read-only violations.
//
//   state | meaning
//   IDLE  | new access decoded; zero-wait or unmapped accesses complete here
//   WAIT  | counting down stall cycles; completes when cnt reaches 0
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_REGIONS = 3,
  parameter logic [ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = '{16'h0000, 16'h4000, 16'h8000},
  parameter logic [ADDR_W-1:0] REGION_MASK [NUM_REGIONS] = '{16'hC000, 16'hF000, 16'h8000},
  parameter logic [WAIT_W-1:0] REGION_WAIT [NUM_REGIONS] = '{4'd0, 4'd2, 4'd1},
  parameter logic              REGION_RO   [NUM_REGIONS] = '{1'b0, 1'b0, 1'b1},
  parameter logic [DATA_W-1:0] OPEN_BUS    = DATA_W'(OPEN_BUS_DEFAULT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_dout,
  input  logic                          cpu_we,
  output logic [DATA_W-1:0]             cpu_din,
  output logic                          cpu_rdy,
  output logic [ADDR_W-1:0]             reg_addr,
  output logic [DATA_W-1:0]             reg_wdata,
  output logic [NUM_REGIONS-1:0]        reg_we,
  output logic [NUM_REGIONS-1:0]        reg_sel,
  input  logic [NUM_REGIONS*DATA_W-1:0] reg_rdata,
  output logic                          err_unmapped,
  output logic                          err_ro_write,
  input  logic                          err_clr
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [NUM_REGIONS-1:0] sel;
  logic                   hit;
  logic [IDX_W-1:0]       idx;
  region_attr_t           attr;
  logic [DATA_W-1:0]      rdata_sel;

  fab_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              done;

  bus_region_decoder #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .addr (cpu_addr),
    .sel  (sel),
    .hit  (hit),
    .idx  (idx)
  );

  always_comb begin
    attr = '0;
    if (hit) begin
      attr.wait_cyc = REGION_WAIT[idx];
      attr.ro       = REGION_RO[idx];
    end
  end

  assign rdata_sel = reg_rdata[idx*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (attr.wait_cyc == '0) begin
          done = 1'b1;
        end else begin
          cnt_d   = attr.wait_cyc - 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdy   = done;
  assign reg_addr  = cpu_addr;
  assign reg_wdata = cpu_dout;
  assign reg_sel   = sel;
  // Gated by rst_n so no strobe leaks out while the fabric is held in reset.
  assign reg_we    = (rst_n && done && cpu_we && !attr.ro) ? sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_din <= '0;
    end else if (done && !cpu_we) begin
      cpu_din <= hit ? rdata_sel : OPEN_BUS;
    end
  end

  // A set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unmapped <= 1'b0;
      err_ro_write <= 1'b0;
    end else begin
      if (done && !hit)                  err_unmapped <= 1'b1;
      else if (err_clr)                  err_unmapped <= 1'b0;
      if (done && hit && cpu_we && attr.ro) err_ro_write <= 1'b1;
      else if (err_clr)                  err_ro_write <= 1'b0;
    end
  end

endmodule

// File: doc/bus_fabric.md
BUS_FABRIC -- requirements
Module: bus_fabric

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, CPU address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter NUM_REGIONS, default 3, decoded region count.
REQ-004 SHALL have parameter REGION_BASE[NUM_REGIONS], default {0x0000,0x4000,0x8000}; region r matches when (cpu_addr & REGION_MASK[r]) == REGION_BASE[r].
REQ-005 SHALL have parameter REGION_MASK[NUM_REGIONS], default {0xC000,0xF000,0x8000}, address match masks.
REQ-006 SHALL have parameter REGION_WAIT[NUM_REGIONS], default {0,2,1}, stall cycles per access, range 0-15.
REQ-007 SHALL have parameter REGION_RO[NUM_REGIONS], default {0,0,1}, read-only flags.
REQ-008 SHALL have parameter OPEN_BUS, default 0xEA, read data returned for unmapped addresses.
REQ-009 Ports: clk in 1, the single clock; rst_n in 1, asynchronous active-low reset.
REQ-010 Ports: cpu_addr in ADDR_W; cpu_dout in DATA_W, CPU write data; cpu_we in 1; cpu_din out DATA_W, registered read data; cpu_rdy out 1, to the CPU RDY input.
REQ-011 Ports: reg_addr out ADDR_W, equal to cpu_addr; reg_wdata out DATA_W, equal to cpu_dout; reg_we out NUM_REGIONS, one-hot; reg_sel out NUM_REGIONS, one-hot; reg_rdata in NUM_REGIONS*DATA_W, packed with region 0 in the LSBs.
REQ-012 Ports: err_unmapped out 1, sticky; err_ro_write out 1, sticky; err_clr in 1, one-cycle clear pulse.

Function
REQ-013 The decode SHALL be combinational; the lowest matching index wins; if no region matches, the access is unmapped and reg_sel is 0.
REQ-014 The FSM SHALL have two states: IDLE and WAIT, with a 4-bit wait counter cnt.
REQ-015 In IDLE with a selected region whose REGION_WAIT is 0, or with an unmapped address, cpu_rdy SHALL be 1 and the access SHALL complete this cycle.
REQ-016 In IDLE with REGION_WAIT[r] = N > 0, cpu_rdy SHALL be 0, cnt SHALL load N-1, and the FSM SHALL enter WAIT.
REQ-017 In WAIT, cpu_rdy SHALL be 0 while cnt != 0 and cnt SHALL decrement each cycle; when cnt == 0, cpu_rdy SHALL be 1, the access completes, and the FSM returns to IDLE.
REQ-018 Each access SHALL therefore stall exactly REGION_WAIT[r] cycles, and cpu_addr is held stable by the CPU while cpu_rdy is 0.
REQ-019 On the completing edge of a read (cpu_we = 0), cpu_din SHALL load reg_rdata[r], or OPEN_BUS when unmapped; otherwise cpu_din SHALL hold its value.
REQ-020 reg_we[r] SHALL be 1 only in the completing cycle of a write to a mapped, non-RO region, exactly one cycle per access.
REQ-021 A write to an RO region SHALL be suppressed and SHALL set err_ro_write on the completing edge.
REQ-022 Any completing access to an unmapped address SHALL set err_unmapped.
REQ-023 err_clr SHALL clear both error flags; an error set event in the same cycle SHALL take priority over the clear.
REQ-024 A change of cpu_addr during WAIT is illegal; the fabric SHALL complete the access against the currently decoded region.

Reset
REQ-025 While rst_n is 0, the FSM SHALL be IDLE, cnt 0, cpu_din 0, err_unmapped 0, err_ro_write 0, and reg_we all 0.
REQ-026 An assertion of rst_n mid-WAIT SHALL abort the access with no reg_we pulse and no error flag set.
REQ-027 In the first cycle after reset release, cpu_rdy SHALL follow the REQ-015/016 rules.

Structure
REQ-028 The state enum, the OPEN_BUS default and the region-table typedef SHALL live in bus_fabric_pkg.
REQ-029 Address matching SHALL be a sub-module, bus_region_decoder, producing the one-hot select and a hit flag.

Verification
REQ-030 Read 0x1234 with reg_rdata[0] = 0x5A -> cpu_rdy stays 1, and cpu_din = 0x5A one edge later.
REQ-031 Read 0x4010 with region 1 = 0x33 -> cpu_rdy is low for exactly 2 cycles, then cpu_din = 0x33.
REQ-032 Write 0xA5 to 0x8000 -> cpu_rdy is low for 1 cycle, reg_we stays 0, and err_ro_write = 1.
REQ-033 Read 0x5000 -> cpu_din = 0xEA and err_unmapped = 1; then err_clr together with a second unmapped access -> the flag stays 1.
REQ-034 Write 0x77 to 0x4000 with rst_n pulsed low during WAIT -> no reg_we pulse, FSM in IDLE, flags 0.
REQ-035 Write 0x11 to 0x0200 -> reg_we = 3'b001 for exactly one cycle and reg_wdata = 0x11.
